// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: default width, op-code
// constants and the control FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH_DEF = 32;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_SLT   = 5'b01100;
    localparam logic [4:0] OP_SLTU  = 5'b01101;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;
    localparam logic [4:0] OP_REMU  = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle of the multi-cycle ALU.
// master drives operations and accepts results, slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Zero;
    logic             Carry;
    logic             Overflow;
    logic             Err;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, D, Zero, Carry, Overflow, Err
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, D, Zero, Carry, Overflow, Err
    );
endinterface

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per
// cycle. start_i loads the operands; WIDTH iterations follow. done_o is
// high during the cycle of the final iteration and result_o then carries
// the final value (taken from the next-state path), so the parent can
// register it on the same edge that retires the last iteration.
// sel_i: 00 MUL low, 01 MULHU high, 10 DIVU quotient, 11 REMU remainder.
module alu_mc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           sel_q;
    logic [WIDTH-1:0]     b_q;
    // Upper half: partial product / remainder; lower half: multiplier / quotient.
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       shf_s;
    logic [WIDTH:0]       sub_s;

    // One iteration step of either the multiplier or the divider.
    always_comb begin
        add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shf_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        sub_s = shf_s - {1'b0, b_q};
        if (!sel_q[1]) begin
            acc_d = {add_s, acc_q[WIDTH-1:1]};
        end else if (!sub_s[WIDTH]) begin
            acc_d = {sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {shf_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done_o   = busy_q && (cnt_q == CNT_LAST);
    assign result_o = sel_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    // Operand load on start, then WIDTH iterations counted by cnt_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sel_q  <= 2'b00;
            b_q    <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            sel_q  <= sel_i;
            b_q    <= b_i;
            acc_q  <= {{WIDTH{1'b0}}, a_i};
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top. Single-cycle ops retire one cycle after accept;
// with ALU_MC_MULDIV_EN defined, MUL/MULHU/DIVU/REMU run on the iterative
// unit and retire WIDTH+1 cycles after accept. Without the macro those
// op-codes are illegal (D=0, Err=1) and the BUSY state is never entered.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_mc_if.slave    bus
);
    state_e           state_q;
    logic [WIDTH-1:0] d_q;
    logic             zero_q, carry_q, ovf_q, err_q, out_valid_q;

    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d, err_d, md_op_s;
    logic [WIDTH:0]   sum_s, dif_s;
    logic [SHW-1:0]   sh_s;
    logic             accept_s, md_done_s;
    logic [WIDTH-1:0] md_res_s;

    assign accept_s = bus.in_valid && (state_q == ST_IDLE);
    assign sh_s     = bus.B[SHW-1:0];
    assign sum_s    = {1'b0, bus.A} + {1'b0, bus.B};
    // A + ~B + 1: carry-out is set exactly when A >= B (unsigned).
    assign dif_s    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle result and flag decode from the presented operands.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        md_op_s = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res_d   = sum_s[WIDTH-1:0];
                carry_d = sum_s[WIDTH];
                ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = dif_s[WIDTH-1:0];
                carry_d = dif_s[WIDTH];
                ovf_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  res_d = bus.A & bus.B;
            OP_OR:   res_d = bus.A | bus.B;
            OP_XOR:  res_d = bus.A ^ bus.B;
            OP_SLL:  res_d = bus.A << sh_s;
            OP_SRL:  res_d = bus.A >> sh_s;
            OP_SRA:  res_d = $signed(bus.A) >>> sh_s;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
`ifdef ALU_MC_MULDIV_EN
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: md_op_s = 1'b1;
`endif
            default: err_d = 1'b1;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    alu_mc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept_s && md_op_s),
        .sel_i    (bus.op[1:0]),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .done_o   (md_done_s),
        .result_o (md_res_s)
    );
`else
    assign md_done_s = 1'b0;
    assign md_res_s  = '0;
`endif

    // Control FSM with registered result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (md_op_s) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            d_q         <= res_d;
                            zero_q      <= (res_d == '0);
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            err_q       <= err_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done_s) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        d_q         <= md_res_s;
                        zero_q      <= (md_res_s == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.Zero      = zero_q;
    assign bus.Carry     = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Err       = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (32- and 16-bit instances) plus a direct
// check of the 8-bit iterative multiply/divide unit.
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus32 ();
    alu_mc_if #(.WIDTH(16)) bus16 ();

    alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    logic       md_start, md_done;
    logic [1:0] md_sel;
    logic [7:0] md_a, md_b, md_res;
    alu_mc_muldiv #(.WIDTH(8)) md8 (
        .clk(clk), .rst(rst), .start_i(md_start), .sel_i(md_sel),
        .a_i(md_a), .b_i(md_b), .done_o(md_done), .result_o(md_res)
    );

    typedef struct {
        logic [31:0] d;
        logic        z, c, v, e;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic c, input logic v,
                                input logic e, input int lat);
        exp_t r;
        r.d = d; r.c = c; r.v = v; r.e = e; r.lat = lat; r.z = (d == 32'd0);
        return r;
    endfunction

    // Reference model of the 32-bit ALU built on 64-bit arithmetic.
    function automatic exp_t model32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [32:0] s;
        logic [63:0] p;
        longint      sa, sb, ss;
        r.d = 32'd0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r.d = s[31:0]; r.c = s[32];
                ss = sa + sb; r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_SUB: begin
                r.d = a - b; r.c = (a >= b);
                ss = sa - sb; r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_AND:  r.d = a & b;
            OP_OR:   r.d = a | b;
            OP_XOR:  r.d = a ^ b;
            OP_SLL:  r.d = a << b[4:0];
            OP_SRL:  r.d = a >> b[4:0];
            OP_SRA:  r.d = 32'($signed(a) >>> b[4:0]);
            OP_SLT:  r.d = {31'd0, (sa < sb)};
            OP_SLTU: r.d = {31'd0, (a < b)};
`ifdef ALU_MC_MULDIV_EN
            OP_MUL:   begin r.d = p[31:0];  r.lat = 33; end
            OP_MULHU: begin r.d = p[63:32]; r.lat = 33; end
            OP_DIVU:  begin r.d = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; r.lat = 33; end
            OP_REMU:  begin r.d = (b == 32'd0) ? a : a % b;            r.lat = 33; end
`endif
            default: r.e = 1'b1;
        endcase
        r.z = (r.d == 32'd0);
        return r;
    endfunction

    // Leaves the caller at a falling edge with the 32-bit ALU idle.
    task automatic wait_idle32(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus32.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(bus32.in_ready), 32'd1);
    endtask

    // Issue one operation, push its expectation, wait for the result, pop and compare.
    task automatic send(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        exp_t x;
        int   n;
        logic rdy_seen;
        sb_q.push_back(e);
        wait_idle32(tag);
        bus32.in_valid = 1'b1; bus32.op = op; bus32.A = a; bus32.B = b;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.op = OP_SUB; bus32.A = ~a; bus32.B = ~b;
        n = 1;
        rdy_seen = bus32.in_ready;
        while (!bus32.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            rdy_seen = rdy_seen | bus32.in_ready;
        end
        x = sb_q.pop_front();
        chk({tag, ".lat"},   32'(n),              32'(x.lat));
        chk({tag, ".rdy0"},  32'(rdy_seen),       32'd0);
        chk({tag, ".D"},     bus32.D,             x.d);
        chk({tag, ".Z"},     32'(bus32.Zero),     32'(x.z));
        chk({tag, ".C"},     32'(bus32.Carry),    32'(x.c));
        chk({tag, ".V"},     32'(bus32.Overflow), 32'(x.v));
        chk({tag, ".E"},     32'(bus32.Err),      32'(x.e));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] rnd_ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
                                 OP_SRA, OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIVU};

    initial begin
        int          n, spur;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [15:0] p8;
        logic [7:0]  e8;

        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.op = 5'd0; bus32.A = 32'd0; bus32.B = 32'd0; bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.op = 5'd0; bus16.A = 16'd0; bus16.B = 16'd0; bus16.out_ready = 1'b1;
        md_start = 1'b0; md_sel = 2'b00; md_a = 8'd0; md_b = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.valid", 32'(bus32.out_valid), 32'd0);
        chk("rst.D",     bus32.D,              32'd0);
        chk("rst.flags", 32'({bus32.Zero, bus32.Carry, bus32.Overflow, bus32.Err}), 32'd0);
        chk("rst.ready", 32'(bus32.in_ready),  32'd1);

        // Directed single-cycle cases.
        send("add_ovf", OP_ADD,  32'h7FFF_FFFF, 32'd1,          mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1));
        send("sub_eq",  OP_SUB,  32'd5,          32'd5,          mk(32'd0,         1'b1, 1'b0, 1'b0, 1));
        send("sub_lt",  OP_SUB,  32'd3,          32'd5,          mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1));
        send("sub_ovf", OP_SUB,  32'h8000_0000, 32'd1,          mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1));
        send("sra",     OP_SRA,  32'h8000_0000, 32'd4,          mk(32'hF800_0000, 1'b0, 1'b0, 1'b0, 1));
        send("srl",     OP_SRL,  32'h8000_0000, 32'h24,         mk(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1));
        send("sll",     OP_SLL,  32'd1,          32'd31,         mk(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1));
        send("xor",     OP_XOR,  32'hF0F0_1234, 32'hFF00_1234, mk(32'h0FF0_0000, 1'b0, 1'b0, 1'b0, 1));
        send("slt",     OP_SLT,  32'hFFFF_FFFF, 32'd1,          mk(32'd1,         1'b0, 1'b0, 1'b0, 1));
        send("sltu",    OP_SLTU, 32'hFFFF_FFFF, 32'd1,          mk(32'd0,         1'b0, 1'b0, 1'b0, 1));
        send("illegal", 5'b00010, 32'd1,         32'd2,          mk(32'd0,         1'b0, 1'b0, 1'b1, 1));
`ifdef ALU_MC_MULDIV_EN
        send("mulhu",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33));
        send("divu0",   OP_DIVU,  32'd7,          32'd0,         mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33));
        send("remu0",   OP_REMU,  32'd7,          32'd0,         mk(32'd7,         1'b0, 1'b0, 1'b0, 33));
        send("mul",     OP_MUL,   32'd3,          32'd4,         mk(32'd12,        1'b0, 1'b0, 1'b0, 33));
        send("divu",    OP_DIVU,  32'd100,        32'd7,         mk(32'd14,        1'b0, 1'b0, 1'b0, 33));
        send("remu",    OP_REMU,  32'd100,        32'd7,         mk(32'd2,         1'b0, 1'b0, 1'b0, 33));
`else
        send("mul_off", OP_MUL,   32'd3,          32'd4,         mk(32'd0,         1'b0, 1'b0, 1'b1, 1));
        send("remu_off", OP_REMU, 32'd7,          32'd0,         mk(32'd0,         1'b0, 1'b0, 1'b1, 1));
`endif

        // Random operations against the model.
        for (int i = 0; i < 16; i++) begin
            op = rnd_ops[$urandom_range(0, 12)];
            a  = $urandom();
            b  = (i % 4 == 0) ? 32'd0 : $urandom();
            send("rnd", op, a, b, model32(op, a, b));
        end

        // Result held while the consumer stalls; new requests ignored.
        wait_idle32("stall");
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.op = OP_ADD; bus32.A = 32'd10; bus32.B = 32'd20;
        @(posedge clk); #1;
        chk("stall.valid0", 32'(bus32.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus32.in_valid = 1'b1; bus32.op = OP_SUB; bus32.A = 32'd99; bus32.B = 32'd1;
            @(posedge clk); #1;
            chk("stall.D",     bus32.D,              32'd30);
            chk("stall.ready", 32'(bus32.in_ready),  32'd0);
            chk("stall.valid", 32'(bus32.out_valid), 32'd1);
        end
        bus32.in_valid = 1'b0;
        @(negedge clk);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall.release", 32'(bus32.out_valid), 32'd0);
        chk("stall.idle",    32'(bus32.in_ready),  32'd1);

        // Reset while an operation is in flight.
        wait_idle32("rstmid");
        bus32.out_ready = 1'b0;
`ifdef ALU_MC_MULDIV_EN
        bus32.op = OP_MULHU;
`else
        bus32.op = OP_ADD;
`endif
        bus32.in_valid = 1'b1; bus32.A = 32'hFFFF_FFFF; bus32.B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.valid", 32'(bus32.out_valid), 32'd0);
        chk("rstmid.D",     bus32.D,              32'd0);
        chk("rstmid.flags", 32'({bus32.Zero, bus32.Carry, bus32.Overflow, bus32.Err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        spur = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus32.out_valid) spur++;
        end
        chk("rstmid.spurious", 32'(spur), 32'd0);
        send("post_rst", OP_ADD, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0, 1'b0, 1));

        // 16-bit instance boundaries.
        @(negedge clk);
        chk("w16.ready", 32'(bus16.in_ready), 32'd1);
        bus16.in_valid = 1'b1; bus16.op = OP_ADD; bus16.A = 16'hFFFF; bus16.B = 16'd1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        chk("w16.valid", 32'(bus16.out_valid), 32'd1);
        chk("w16.D",     32'(bus16.D),         32'd0);
        chk("w16.C",     32'(bus16.Carry),     32'd1);
        chk("w16.Z",     32'(bus16.Zero),      32'd1);
        chk("w16.V",     32'(bus16.Overflow),  32'd0);
        @(negedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b1; bus16.op = OP_SUB; bus16.A = 16'h8000; bus16.B = 16'd1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        chk("w16s.D", 32'(bus16.D),        32'h7FFF);
        chk("w16s.V", 32'(bus16.Overflow), 32'd1);
        chk("w16s.C", 32'(bus16.Carry),    32'd1);

        // 8-bit iterative unit on its own.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            md_start = 1'b1;
            md_sel   = 2'(i % 4);
            md_a     = 8'($urandom_range(0, 255));
            md_b     = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            p8 = {8'd0, md_a} * {8'd0, md_b};
            case (md_sel)
                2'b00:   e8 = p8[7:0];
                2'b01:   e8 = p8[15:8];
                2'b10:   e8 = (md_b == 8'd0) ? 8'hFF : md_a / md_b;
                default: e8 = (md_b == 8'd0) ? md_a : md_a % md_b;
            endcase
            @(posedge clk); #1;
            md_start = 1'b0;
            n = 1;
            while (!md_done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("md8.lat", 32'(n),      32'd8);
            chk("md8.res", 32'(md_res), 32'(e8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands/op presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port op  input  5  operation code per REQ-012.
REQ-008 SHALL have ports A, B  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports D output WIDTH result; Zero, Carry, Overflow, Err output 1 each, all registered with D.

Function
REQ-012 SHALL decode op: 00000 ADD, 00001 SUB, 00100 AND, 00101 OR, 00110 XOR, 01000 SLL, 01001 SRL, 01010 SRA, 01100 SLT, 01101 SLTU, 10000 MUL (low WIDTH), 10001 MULHU (high WIDTH, unsigned), 10010 DIVU, 10011 REMU; any other code gives D=0, Err=1.
REQ-013 SHALL run FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept on rising edge with in_valid&&in_ready, capturing op, A, B.
REQ-015 SHALL, for op[4]=0 or illegal op, go IDLE->DONE directly; out_valid=1 the cycle after accept (latency 1).
REQ-016 SHALL, for MUL/MULHU/DIVU/REMU, go IDLE->BUSY, iterate one bit per cycle for WIDTH cycles, then ->DONE; out_valid=1 exactly WIDTH+1 cycles after accept.
REQ-017 SHALL hold D and flags stable in DONE until out_ready=1, then go to IDLE; out_ready while DONE and in_valid have no other effect.
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH; Carry = carry-out (SUB: 1 when A>=B unsigned); Overflow = signed overflow; both 0 for non-add ops.
REQ-019 SHALL produce SLT/SLTU as 0 or 1 zero-extended to WIDTH.
REQ-020 SHALL set Zero=(D==0) for every op.
REQ-021 SHALL on DIVU/REMU with B=0 return quotient all-ones, remainder A, Err=0, same latency.
REQ-022 SHALL ignore in_valid, op, A, B outside IDLE.

Reset
REQ-023 SHALL on rst=1 immediately force state IDLE, in_ready=1 after release, out_valid=0, D=0, Zero=0, Carry=0, Overflow=0, Err=0, iteration counter 0.
REQ-024 SHALL abandon any in-flight BUSY or DONE operation on reset without emitting a result.

Configuration
REQ-025 SHALL provide macro ALU_MC_MULDIV_EN: defined -> REQ-016/021 as stated; undefined -> iterative unit not instantiated, op 100xx treated as illegal (D=0, Err=1, latency 1), BUSY unreachable.

Structure
REQ-026 SHALL place op-code constants, FSM state encoding and default WIDTH in shared package alu_pkg.
REQ-027 SHALL implement iterative shift-add multiply / restoring divide in one sub-module alu_mc_muldiv (start, done, WIDTH-parametrised).

Verification
REQ-028 SHALL cover: ADD A=0x7FFFFFFF B=1 -> D=0x80000000, Overflow=1, Carry=0, out_valid 1 cycle after accept.
REQ-029 SHALL cover: SUB A=5 B=5 -> D=0, Zero=1, Carry=1; SRA A=0x80000000 B=4 -> D=0xF8000000.
REQ-030 SHALL cover: MULHU A=0xFFFFFFFF B=0xFFFFFFFF -> D=0xFFFFFFFE, out_valid exactly 33 cycles after accept, in_ready=0 meanwhile.
REQ-031 SHALL cover: DIVU A=7 B=0 -> D=0xFFFFFFFF; REMU A=7 B=0 -> D=7; Err=0.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> D stable, in_ready=0; reset asserted mid-BUSY -> out_valid=0, next op accepted normally.
REQ-033 SHALL cover: build without ALU_MC_MULDIV_EN, MUL A=3 B=4 -> D=0, Err=1, latency 1; WIDTH=16 ADD 0xFFFF+1 -> D=0, Carry=1.
